// File: rtl/ddr_arbiter.sv
// Two-requester burst arbiter for the single DDR3 Avalon-style port.
// A = ROM download writer, B = frame buffer / sprite reader. Whole bursts
// are granted round-robin; read beats return only to the granted side.
module ddr_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               a_rd,
    input  logic               a_wr,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [BURST_W-1:0] a_burst,
    input  logic [7:0]         a_mask,
    input  logic [DATA_W-1:0]  a_din,
    output logic               a_wait_req,
    output logic               a_valid,
    output logic [DATA_W-1:0]  a_dout,
    output logic               a_done,

    input  logic               b_rd,
    input  logic               b_wr,
    input  logic [ADDR_W-1:0]  b_addr,
    input  logic [BURST_W-1:0] b_burst,
    input  logic [7:0]         b_mask,
    input  logic [DATA_W-1:0]  b_din,
    output logic               b_wait_req,
    output logic               b_valid,
    output logic [DATA_W-1:0]  b_dout,
    output logic               b_done,

    output logic               ddr_rd,
    output logic               ddr_wr,
    output logic [ADDR_W-1:0]  ddr_addr,
    output logic [BURST_W-1:0] ddr_burst,
    output logic [7:0]         ddr_mask,
    output logic [DATA_W-1:0]  ddr_din,
    input  logic [DATA_W-1:0]  ddr_dout,
    input  logic               ddr_wait_req,
    input  logic               ddr_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t             state_q;
    logic               grant_q;   // 0 = A, 1 = B
    logic               last_q;    // side that won the previous arbitration
    logic [BURST_W-1:0] cnt_q;
    logic [BURST_W-1:0] len_q;

    logic               g_rd;
    logic               g_wr;
    logic [ADDR_W-1:0]  g_addr;
    logic [BURST_W-1:0] g_burst;
    logic [7:0]         g_mask;
    logic [DATA_W-1:0]  g_din;
    logic [BURST_W-1:0] g_len;
    logic               g_wait;
    logic               req_a;
    logic               req_b;
    logic               winner_b;
    logic               last_beat;
    logic               rd_go;
    logic               wr_go;
    logic               rd_beat;
    logic               wr_beat;
    logic               done;

    // Select the granted requester's command fields
    always_comb begin
        g_rd    = grant_q ? b_rd    : a_rd;
        g_wr    = grant_q ? b_wr    : a_wr;
        g_addr  = grant_q ? b_addr  : a_addr;
        g_burst = grant_q ? b_burst : a_burst;
        g_mask  = grant_q ? b_mask  : a_mask;
        g_din   = grant_q ? b_din   : a_din;
    end

    // Arbitration, burst acceptance and beat accounting
    always_comb begin
        req_a     = a_rd | a_wr;
        req_b     = b_rd | b_wr;
        winner_b  = req_b & (~req_a | ~last_q);
        g_len     = (g_burst == '0) ? BURST_W'(1) : g_burst;
        last_beat = (cnt_q == (len_q - BURST_W'(1)));
        rd_go     = (state_q == ST_GRANT) & g_rd & ~ddr_wait_req;
        wr_go     = (state_q == ST_GRANT) & ~g_rd & g_wr & ~ddr_wait_req;
        rd_beat   = (state_q == ST_READ) & ddr_valid & ~reset;
        wr_beat   = (state_q == ST_WRITE) & g_wr & ~ddr_wait_req;
        done      = ~reset & ((wr_go & (g_len == BURST_W'(1)))
                              | (rd_beat & last_beat)
                              | (wr_beat & last_beat));
    end

    // DDR-side strobes and per-requester handshakes
    always_comb begin
        ddr_rd    = 1'b0;
        ddr_wr    = 1'b0;
        g_wait    = 1'b1;
        ddr_addr  = g_addr;
        ddr_burst = g_burst;
        ddr_mask  = g_mask;
        ddr_din   = g_din;
        case (state_q)
            ST_GRANT: begin
                ddr_rd = g_rd & ~reset;
                ddr_wr = g_wr & ~g_rd & ~reset;
                g_wait = ddr_wait_req;
            end
            ST_WRITE: begin
                ddr_wr = g_wr & ~reset;
                g_wait = ddr_wait_req;
            end
            default: ;
        endcase
        a_wait_req = grant_q ? 1'b1 : g_wait;
        b_wait_req = grant_q ? g_wait : 1'b1;
        a_valid    = ~grant_q & rd_beat;
        b_valid    = grant_q & rd_beat;
        a_done     = ~grant_q & done;
        b_done     = grant_q & done;
        a_dout     = ddr_dout;
        b_dout     = ddr_dout;
    end

    // Burst state machine; grant is held until the final beat of the burst
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_a | req_b) begin
                        grant_q <= winner_b;
                        last_q  <= winner_b;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rd_go) begin
                        len_q   <= g_len;
                        cnt_q   <= '0;
                        state_q <= ST_READ;
                    end else if (wr_go) begin
                        len_q <= g_len;
                        if (g_len == BURST_W'(1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= BURST_W'(1);
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (ddr_valid) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + BURST_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + BURST_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
